// File: rtl/dma_req_arbiter_pkg.sv
// Shared DMA definitions: arbiter state encoding, requester ids and default bus widths.
// Imported by the arbiter, its interface and its round-robin picker.
package dma_pkg;

    localparam int DMA_ADDR_WIDTH      = 32;
    localparam int DMA_BURST_LEN_WIDTH = 8;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2,
        ARB_REL  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] req_onehot(input logic id);
        return (id == REQ_DCACHE) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dma_req_arbiter_if.sv
// Requester and DMA handshake bundle of the arbiter; slave is the arbiter's view,
// master is the view of the environment driving requesters and the DMA.
interface dma_req_arbiter_if
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = DMA_ADDR_WIDTH,
    parameter int BURST_LEN_WIDTH = DMA_BURST_LEN_WIDTH
);
    logic [1:0]                   req_valid;
    logic [1:0]                   req_is_write;
    logic [2*ADDR_WIDTH-1:0]      req_addr;
    logic [2*BURST_LEN_WIDTH-1:0] req_burst_len;
    logic [1:0]                   req_ready;
    logic [1:0]                   req_done;

    logic                         dma_page_fault_happen;
    logic [ADDR_WIDTH-1:0]        dma_page_fault_addr;
    logic [BURST_LEN_WIDTH-1:0]   dma_page_fault_burst_len;
    logic                         dma_page_fault_done;
    logic                         dma_write_back_happen;
    logic [ADDR_WIDTH-1:0]        dma_write_back_addr;
    logic [BURST_LEN_WIDTH-1:0]   dma_write_back_burst_len;
    logic                         dma_write_back_done;

    logic                         busy;
    logic                         grant_id;
    logic                         timeout_err;

    modport slave (
        input  req_valid, req_is_write, req_addr, req_burst_len,
        input  dma_page_fault_done, dma_write_back_done,
        output req_ready, req_done,
        output dma_page_fault_happen, dma_page_fault_addr, dma_page_fault_burst_len,
        output dma_write_back_happen, dma_write_back_addr, dma_write_back_burst_len,
        output busy, grant_id, timeout_err
    );

    modport master (
        output req_valid, req_is_write, req_addr, req_burst_len,
        output dma_page_fault_done, dma_write_back_done,
        input  req_ready, req_done,
        input  dma_page_fault_happen, dma_page_fault_addr, dma_page_fault_burst_len,
        input  dma_write_back_happen, dma_write_back_addr, dma_write_back_burst_len,
        input  busy, grant_id, timeout_err
    );

endinterface

// File: rtl/dma_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
// Purely combinational; the caller owns the last-grant state.
module rr_arb2
    import dma_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_gnt_id,
    output logic       o_any
);

    assign o_any    = |i_valid;
    assign o_gnt_id = (i_valid == 2'b11) ? ~i_last : (i_valid[1] ? REQ_DCACHE : REQ_ICACHE);

endmodule

// File: rtl/dma_req_arbiter.sv
// Grants the single DMA engine to the I-cache or D-cache, one fill/write-back at a time.
// Holds the DMA request level until done, then waits for done to drop before re-arming.
module dma_req_arbiter
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = DMA_ADDR_WIDTH,
    parameter int BURST_LEN_WIDTH = DMA_BURST_LEN_WIDTH,
    parameter int TIMEOUT_CYCLES  = 4096
)(
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    dma_req_arbiter_if.slave  bus
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                 r_state;
    logic                       r_last_grant;
    logic                       r_grant_id;
    logic                       r_is_wr;
    logic                       r_busy;
    logic [1:0]                 r_req_ready;
    logic [1:0]                 r_req_done;
    logic                       r_pf_happen;
    logic [ADDR_WIDTH-1:0]      r_pf_addr;
    logic [BURST_LEN_WIDTH-1:0] r_pf_len;
    logic                       r_wb_happen;
    logic [ADDR_WIDTH-1:0]      r_wb_addr;
    logic [BURST_LEN_WIDTH-1:0] r_wb_len;
    logic                       r_timeout_err;
    logic [CNT_W-1:0]           r_to_cnt;

    arb_state_t                 w_state_nxt;
    logic                       w_gnt_id;
    logic                       w_any;
    logic                       w_grant;
    logic                       w_done_fire;
    logic                       w_active;
    logic                       w_sel_wr;
    logic [ADDR_WIDTH-1:0]      w_sel_addr;
    logic [BURST_LEN_WIDTH-1:0] w_sel_len;

    rr_arb2 u_rr_arb2 (
        .i_valid  (bus.req_valid),
        .i_last   (r_last_grant),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    assign w_sel_wr   = bus.req_is_write[w_gnt_id];
    assign w_sel_addr = w_gnt_id ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                 : bus.req_addr[0 +: ADDR_WIDTH];
    assign w_sel_len  = w_gnt_id ? bus.req_burst_len[BURST_LEN_WIDTH +: BURST_LEN_WIDTH]
                                 : bus.req_burst_len[0 +: BURST_LEN_WIDTH];
    assign w_active   = (r_state == ARB_RD) || (r_state == ARB_WR);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done_fire = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // A done still high from the previous transfer must not be mistaken for completion.
                if (w_any && !bus.dma_page_fault_done && !bus.dma_write_back_done) begin
                    w_grant     = 1'b1;
                    w_state_nxt = w_sel_wr ? ARB_WR : ARB_RD;
                end
            end
            ARB_RD: begin
                if (bus.dma_page_fault_done) begin
                    w_done_fire = 1'b1;
                    w_state_nxt = ARB_REL;
                end
            end
            ARB_WR: begin
                if (bus.dma_write_back_done) begin
                    w_done_fire = 1'b1;
                    w_state_nxt = ARB_REL;
                end
            end
            ARB_REL: begin
                if (r_is_wr ? !bus.dma_write_back_done : !bus.dma_page_fault_done) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state       <= ARB_IDLE;
            r_last_grant  <= REQ_DCACHE;
            r_grant_id    <= 1'b0;
            r_is_wr       <= 1'b0;
            r_busy        <= 1'b0;
            r_req_ready   <= 2'b00;
            r_req_done    <= 2'b00;
            r_pf_happen   <= 1'b0;
            r_pf_addr     <= '0;
            r_pf_len      <= '0;
            r_wb_happen   <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_len      <= '0;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ARB_IDLE);
            r_req_ready <= 2'b00;
            r_req_done  <= 2'b00;

            if (w_grant) begin
                r_req_ready  <= req_onehot(w_gnt_id);
                r_grant_id   <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_is_wr      <= w_sel_wr;
                r_to_cnt     <= '0;
                if (w_sel_wr) begin
                    r_wb_happen <= 1'b1;
                    r_wb_addr   <= w_sel_addr;
                    r_wb_len    <= w_sel_len;
                end else begin
                    r_pf_happen <= 1'b1;
                    r_pf_addr   <= w_sel_addr;
                    r_pf_len    <= w_sel_len;
                end
            end

            if (w_done_fire) begin
                r_pf_happen <= 1'b0;
                r_wb_happen <= 1'b0;
                r_req_done  <= req_onehot(r_grant_id);
            end

            // The DMA cannot be aborted, so a timeout only flags and keeps waiting.
            if (w_active) begin
                if (r_to_cnt != TO_LAST) begin
                    r_to_cnt <= r_to_cnt + CNT_W'(1);
                end else begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready                = r_req_ready;
    assign bus.req_done                 = r_req_done;
    assign bus.dma_page_fault_happen    = r_pf_happen;
    assign bus.dma_page_fault_addr      = r_pf_addr;
    assign bus.dma_page_fault_burst_len = r_pf_len;
    assign bus.dma_write_back_happen    = r_wb_happen;
    assign bus.dma_write_back_addr      = r_wb_addr;
    assign bus.dma_write_back_burst_len = r_wb_len;
    assign bus.busy                     = r_busy;
    assign bus.grant_id                 = r_grant_id;
    assign bus.timeout_err              = r_timeout_err;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: a table of complete transactions plus
// hand-written sequences for tie order, stale done, async reset, back-to-back and timeout.
module tb_dma_req_arbiter;

    logic cpu_clk;
    logic cpu_rst;
    int   checks;
    int   errors;

    dma_req_arbiter_if #(.ADDR_WIDTH(32), .BURST_LEN_WIDTH(8)) bus ();

    dma_req_arbiter #(
        .ADDR_WIDTH      (32),
        .BURST_LEN_WIDTH (8),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [7:0]  l0;
        logic [7:0]  l1;
        int          act_cyc;
        int          done_hold;
        logic [1:0]  exp_ready;
        logic        exp_id;
        logic        exp_wb;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.dma_page_fault_done = 1'b0;
        bus.dma_write_back_done = 1'b0;
        repeat (2) step();
        cpu_rst = 1'b0;
        step();
    endtask

    // Finishes the running transfer: done high for hold cycles, then low until IDLE.
    task automatic complete(input string name, input logic wb, input logic [1:0] exp_done,
                            input int hold);
        if (wb) bus.dma_write_back_done = 1'b1;
        else    bus.dma_page_fault_done = 1'b1;
        step();
        chk({name, " req_done"}, bus.req_done, exp_done);
        chk({name, " happen_clr"}, {bus.dma_page_fault_happen, bus.dma_write_back_happen}, 2'b00);
        chk({name, " busy_rel"}, bus.busy, 1'b1);
        for (int k = 1; k < hold; k++) begin
            step();
            chk($sformatf("%s done_pulse_%0d", name, k), bus.req_done, 2'b00);
            chk($sformatf("%s busy_held_%0d", name, k), bus.busy, 1'b1);
        end
        bus.dma_write_back_done = 1'b0;
        bus.dma_page_fault_done = 1'b0;
        step();
        chk({name, " busy_idle"}, bus.busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string n;
        n = $sformatf("vec%0d", idx);
        bus.req_valid     = v.valid;
        bus.req_is_write  = v.wr;
        bus.req_addr      = {v.a1, v.a0};
        bus.req_burst_len = {v.l1, v.l0};
        step();
        chk({n, " ready"}, bus.req_ready, v.exp_ready);
        chk({n, " grant_id"}, bus.grant_id, v.exp_id);
        chk({n, " happen"}, {bus.dma_page_fault_happen, bus.dma_write_back_happen},
            {~v.exp_wb, v.exp_wb});
        chk({n, " addr"}, v.exp_wb ? bus.dma_write_back_addr : bus.dma_page_fault_addr, v.exp_addr);
        chk({n, " len"}, v.exp_wb ? bus.dma_write_back_burst_len : bus.dma_page_fault_burst_len,
            v.exp_len);
        chk({n, " busy"}, bus.busy, 1'b1);
        bus.req_valid = 2'b00;
        repeat (v.act_cyc) step();
        chk({n, " ready_pulse"}, bus.req_ready, 2'b00);
        chk({n, " happen_hold"}, v.exp_wb ? bus.dma_write_back_happen : bus.dma_page_fault_happen, 1'b1);
        complete(n, v.exp_wb, v.exp_ready, v.done_hold);
    endtask

    always @(negedge cpu_clk) begin
        if (!cpu_rst && bus.dma_page_fault_happen && bus.dma_write_back_happen) begin
            errors++;
            $display("FAIL both_happen: got 11 expected at most one high at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic [1:0] exp_order [3];
        checks = 0;
        errors = 0;
        bus.req_valid = 2'b00;
        bus.req_is_write = 2'b00;
        bus.req_addr = '0;
        bus.req_burst_len = '0;
        bus.dma_page_fault_done = 1'b0;
        bus.dma_write_back_done = 1'b0;

        //           valid  wr     a0            a1            l0     l1      act hold ready  id  wb  addr          len
        vt[0] = '{2'b01, 2'b00, 32'h0000_1000, 32'h0,        8'd8,  8'd0,   20, 4, 2'b01, 1'b0, 1'b0, 32'h0000_1000, 8'd8};
        vt[1] = '{2'b11, 2'b10, 32'h0000_2000, 32'h0000_3000, 8'd4,  8'd16,  3, 1, 2'b10, 1'b1, 1'b1, 32'h0000_3000, 8'd16};
        vt[2] = '{2'b11, 2'b10, 32'h0000_2000, 32'h0000_3000, 8'd4,  8'd16,  3, 1, 2'b01, 1'b0, 1'b0, 32'h0000_2000, 8'd4};
        vt[3] = '{2'b10, 2'b10, 32'h0,        32'h0000_4000, 8'd0,  8'd0,   2, 2, 2'b10, 1'b1, 1'b1, 32'h0000_4000, 8'd0};
        vt[4] = '{2'b01, 2'b01, 32'hFFFF_FFFC, 32'h0,        8'hFF, 8'd0,   1, 1, 2'b01, 1'b0, 1'b1, 32'hFFFF_FFFC, 8'hFF};
        vt[5] = '{2'b11, 2'b00, 32'h0000_5000, 32'h0000_6000, 8'd1,  8'd2,   2, 1, 2'b10, 1'b1, 1'b0, 32'h0000_6000, 8'd2};

        // Reset state
        cpu_rst = 1'b1;
        #12;
        chk("rst happen", {bus.dma_page_fault_happen, bus.dma_write_back_happen}, 2'b00);
        chk("rst ready_done", {bus.req_ready, bus.req_done}, 4'h0);
        chk("rst busy_gid_err", {bus.busy, bus.grant_id, bus.timeout_err}, 3'b000);
        chk("rst addrs", {bus.dma_page_fault_addr, bus.dma_write_back_addr}, 64'h0);
        chk("rst lens", {bus.dma_page_fault_burst_len, bus.dma_write_back_burst_len}, 16'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Tie held from reset: grants alternate 0, 1, 0
        do_reset();
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
        bus.req_valid     = 2'b11;
        bus.req_is_write  = 2'b10;
        bus.req_addr      = {32'h0000_3000, 32'h0000_2000};
        bus.req_burst_len = {8'd16, 8'd4};
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (bus.req_ready == 2'b00 && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("tie%0d ready", r), bus.req_ready, exp_order[r]);
            if (bus.req_ready == 2'b10) begin
                chk($sformatf("tie%0d wb", r), {bus.dma_write_back_happen, bus.dma_write_back_addr},
                    {1'b1, 32'h0000_3000});
                bus.req_valid[1] = 1'b0;
                complete($sformatf("tie%0d", r), 1'b1, 2'b10, 1);
                if (r < 2) bus.req_valid[1] = 1'b1;
            end else begin
                chk($sformatf("tie%0d pf", r), {bus.dma_page_fault_happen, bus.dma_page_fault_addr},
                    {1'b1, 32'h0000_2000});
                bus.req_valid[0] = 1'b0;
                complete($sformatf("tie%0d", r), 1'b0, 2'b01, 1);
                if (r < 2) bus.req_valid[0] = 1'b1;
            end
        end
        bus.req_valid = 2'b00;

        // Stale write-back done blocks the grant until it falls
        do_reset();
        bus.dma_write_back_done = 1'b1;
        bus.req_valid     = 2'b10;
        bus.req_is_write  = 2'b10;
        bus.req_addr      = {32'h0000_7000, 32'h0};
        bus.req_burst_len = {8'd5, 8'd0};
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("stale%0d idle", k), {bus.busy, bus.req_ready}, 3'b000);
        end
        bus.dma_write_back_done = 1'b0;
        step();
        chk("stale grant", {bus.req_ready, bus.dma_write_back_happen}, 3'b101);
        chk("stale addr", bus.dma_write_back_addr, 32'h0000_7000);
        bus.req_valid = 2'b00;
        complete("stale", 1'b1, 2'b10, 1);

        // Back-to-back from requester 1: write-back then fill
        bus.req_valid     = 2'b10;
        bus.req_is_write  = 2'b10;
        bus.req_addr      = {32'h0000_A000, 32'h0};
        bus.req_burst_len = {8'd3, 8'd0};
        step();
        chk("b2b wb ready", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        step();
        bus.dma_write_back_done = 1'b1;
        step();
        chk("b2b wb done", bus.req_done, 2'b10);
        bus.dma_write_back_done = 1'b0;
        bus.req_valid     = 2'b10;
        bus.req_is_write  = 2'b00;
        bus.req_addr      = {32'h0000_B000, 32'h0};
        bus.req_burst_len = {8'd7, 8'd0};
        n = 0;
        while (bus.req_ready == 2'b00 && n < 10) begin
            step();
            n++;
        end
        chk("b2b spacing", n, 2);
        chk("b2b fill", {bus.req_ready, bus.dma_page_fault_happen, bus.dma_page_fault_addr},
            {2'b10, 1'b1, 32'h0000_B000});
        chk("b2b wb addr kept", bus.dma_write_back_addr, 32'h0000_A000);
        chk("b2b fill len", bus.dma_page_fault_burst_len, 8'd7);
        bus.req_valid = 2'b00;
        complete("b2b fill", 1'b0, 2'b10, 1);

        // Asynchronous reset during a fill, then a tie goes to requester 0
        bus.req_valid     = 2'b01;
        bus.req_is_write  = 2'b00;
        bus.req_addr      = {32'h0, 32'h0000_8000};
        bus.req_burst_len = {8'd0, 8'd5};
        step();
        chk("arst pre", bus.dma_page_fault_happen, 1'b1);
        bus.req_valid = 2'b00;
        step();
        @(negedge cpu_clk);
        #2 cpu_rst = 1'b1;
        #1;
        chk("arst happen", {bus.dma_page_fault_happen, bus.busy, bus.grant_id}, 3'b000);
        chk("arst addr", {bus.dma_page_fault_addr, bus.dma_page_fault_burst_len}, 40'h0);
        @(negedge cpu_clk);
        #1 cpu_rst = 1'b0;
        bus.req_valid     = 2'b11;
        bus.req_is_write  = 2'b10;
        bus.req_addr      = {32'h0000_3000, 32'h0000_2000};
        bus.req_burst_len = {8'd16, 8'd4};
        step();
        chk("arst tie", {bus.req_ready, bus.grant_id, bus.dma_page_fault_happen}, 4'b0101);
        bus.req_valid = 2'b00;
        complete("arst", 1'b0, 2'b01, 1);

        // Timeout: 16 active cycles with no done
        do_reset();
        chk("to clear", bus.timeout_err, 1'b0);
        bus.req_valid     = 2'b01;
        bus.req_is_write  = 2'b00;
        bus.req_addr      = {32'h0, 32'h0000_9000};
        bus.req_burst_len = {8'd0, 8'd9};
        step();
        chk("to grant", bus.dma_page_fault_happen, 1'b1);
        bus.req_valid = 2'b00;
        repeat (15) step();
        chk("to before", bus.timeout_err, 1'b0);
        step();
        chk("to set", {bus.timeout_err, bus.dma_page_fault_happen}, 2'b11);
        complete("to", 1'b0, 2'b01, 1);
        chk("to sticky", bus.timeout_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
